// File: rtl/sm_ctx_swap_ctrl.sv
// SM context-swap sequencer: saves the outgoing SM's registers to the context store,
// then restores the incoming SM's registers from it, and pulses swap_done_o.
module sm_ctx_swap_ctrl #(
  parameter int unsigned SM_LOG  = 2,
  parameter int unsigned REG_LOG = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      swap_req_i,
  input  logic [SM_LOG-1:0]         cur_sm_i,
  input  logic [SM_LOG-1:0]         next_sm_i,
  output logic                      rf_rd_en_o,
  output logic [REG_LOG-1:0]        rf_rd_addr_o,
  input  logic [DATA_W-1:0]         rf_rd_data_i,
  output logic                      rf_wr_en_o,
  output logic [REG_LOG-1:0]        rf_wr_addr_o,
  output logic [DATA_W-1:0]         rf_wr_data_o,
  output logic                      cs_req_o,
  output logic                      cs_we_o,
  output logic [SM_LOG+REG_LOG-1:0] cs_addr_o,
  output logic [DATA_W-1:0]         cs_wdata_o,
  input  logic                      cs_gnt_i,
  input  logic                      cs_rvalid_i,
  input  logic [DATA_W-1:0]         cs_rdata_i,
  output logic                      busy_o,
  output logic                      swap_done_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SAVE_RD   = 3'd1;
  localparam logic [2:0] SAVE_WR   = 3'd2;
  localparam logic [2:0] LOAD_REQ  = 3'd3;
  localparam logic [2:0] LOAD_WAIT = 3'd4;
  localparam logic [2:0] LOAD_WR   = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam logic [REG_LOG-1:0] LAST_IDX = {REG_LOG{1'b1}};

  logic [2:0]         state_q, state_d;
  logic [REG_LOG-1:0] idx_q, idx_d;
  logic [SM_LOG-1:0]  src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               first_q, first_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    first_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_req_i) begin
          src_d   = cur_sm_i;
          dst_d   = next_sm_i;
          idx_d   = '0;
          state_d = (cur_sm_i == next_sm_i) ? DONE : SAVE_RD;
        end
      end
      SAVE_RD: begin
        first_d = 1'b1;
        state_d = SAVE_WR;
      end
      SAVE_WR: begin
        // Read data is only valid in the first SAVE_WR cycle; hold it across grant stalls.
        if (first_q) data_d = rf_rd_data_i;
        if (cs_gnt_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD_REQ;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SAVE_RD;
          end
        end
      end
      LOAD_REQ: begin
        if (cs_gnt_i) state_d = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (cs_rvalid_i) begin
          data_d  = cs_rdata_i;
          state_d = LOAD_WR;
        end
      end
      LOAD_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs; buses are forced to zero outside the states that own them.
  always_comb begin
    rf_rd_en_o   = 1'b0;
    rf_rd_addr_o = '0;
    rf_wr_en_o   = 1'b0;
    rf_wr_addr_o = '0;
    rf_wr_data_o = '0;
    cs_req_o     = 1'b0;
    cs_we_o      = 1'b0;
    cs_addr_o    = '0;
    cs_wdata_o   = '0;
    swap_done_o  = 1'b0;
    busy_o       = (state_q != IDLE);
    case (state_q)
      SAVE_RD: begin
        rf_rd_en_o   = 1'b1;
        rf_rd_addr_o = idx_q;
      end
      SAVE_WR: begin
        cs_req_o   = 1'b1;
        cs_we_o    = 1'b1;
        cs_addr_o  = {src_q, idx_q};
        cs_wdata_o = first_q ? rf_rd_data_i : data_q;
      end
      LOAD_REQ: begin
        cs_req_o  = 1'b1;
        cs_addr_o = {dst_q, idx_q};
      end
      LOAD_WR: begin
        rf_wr_en_o   = 1'b1;
        rf_wr_addr_o = idx_q;
        rf_wr_data_o = data_q;
      end
      DONE:    swap_done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm_ctx_swap_ctrl.sv
// Directed bench for sm_ctx_swap_ctrl with a register-file model and a context-store model
// that supports grant stalls and delayed read responses.
module tb_sm_ctx_swap_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        swap_req = 1'b0;
  logic [1:0]  cur_sm = '0, next_sm = '0;
  logic        rf_rd_en, rf_wr_en, cs_req, cs_we, cs_gnt, cs_rvalid, busy, swap_done;
  logic [1:0]  rf_rd_addr, rf_wr_addr;
  logic [3:0]  cs_addr;
  logic [31:0] rf_rd_data, rf_wr_data, cs_wdata, cs_rdata;

  always #5 clk = ~clk;

  sm_ctx_swap_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .swap_req_i   (swap_req),
    .cur_sm_i     (cur_sm),
    .next_sm_i    (next_sm),
    .rf_rd_en_o   (rf_rd_en),
    .rf_rd_addr_o (rf_rd_addr),
    .rf_rd_data_i (rf_rd_data),
    .rf_wr_en_o   (rf_wr_en),
    .rf_wr_addr_o (rf_wr_addr),
    .rf_wr_data_o (rf_wr_data),
    .cs_req_o     (cs_req),
    .cs_we_o      (cs_we),
    .cs_addr_o    (cs_addr),
    .cs_wdata_o   (cs_wdata),
    .cs_gnt_i     (cs_gnt),
    .cs_rvalid_i  (cs_rvalid),
    .cs_rdata_i   (cs_rdata),
    .busy_o       (busy),
    .swap_done_o  (swap_done)
  );

  // Models and scoreboard counters
  logic [31:0] rf_mem [4];
  logic [31:0] store [16];
  logic [31:0] rd_q = 32'h0;
  logic        mem_init = 1'b1;
  int          stall_req = 0, stall_used = 0;
  logic [3:0]  stall_addr = 4'd1;
  logic        slow_en = 1'b0;
  logic [3:0]  slow_addr = 4'd15;
  logic        pend = 1'b0;
  int          rv_cnt = 0;
  logic [31:0] rv_data = 32'h0;
  logic        rvalid_prev = 1'b0;
  int          rf_wr_cnt = 0, cs_wr_cnt = 0, cs_rd_cnt = 0, done_cnt = 0, seq_err = 0;

  assign cs_gnt     = !(stall_used < stall_req && cs_req && cs_we && cs_addr == stall_addr);
  assign cs_rvalid  = pend && (rv_cnt == 0);
  assign cs_rdata   = cs_rvalid ? rv_data : 32'hbad0bad0;
  assign rf_rd_data = rd_q;

  always @(posedge clk) begin
    rd_q        <= rf_rd_en ? rf_mem[rf_rd_addr] : 32'hdeadbeef;
    rvalid_prev <= cs_rvalid;
    if (mem_init) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 32'hA0 + i;
      for (int j = 0; j < 16; j++) store[j] <= 32'h5000 + j;
    end else begin
      if (rf_wr_en) begin
        rf_mem[rf_wr_addr] <= rf_wr_data;
        rf_wr_cnt <= rf_wr_cnt + 1;
        if (!rvalid_prev) seq_err <= seq_err + 1;
      end
      if (cs_req && cs_gnt && cs_we) begin
        store[cs_addr] <= cs_wdata;
        cs_wr_cnt <= cs_wr_cnt + 1;
      end
    end
    if (cs_req && !cs_gnt) stall_used <= stall_used + 1;
    if (pend) begin
      if (rv_cnt == 0) pend <= 1'b0;
      else rv_cnt <= rv_cnt - 1;
    end
    if (cs_req && cs_gnt && !cs_we) begin
      pend      <= 1'b1;
      rv_cnt    <= (slow_en && cs_addr == slow_addr) ? 5 : 0;
      rv_data   <= store[cs_addr];
      cs_rd_cnt <= cs_rd_cnt + 1;
    end
    if (swap_done) done_cnt <= done_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check(tag, {50'h0, busy, swap_done, rf_rd_en, rf_wr_en, cs_req, cs_we,
                rf_rd_addr, rf_wr_addr, cs_addr}, 64'h0);
    check({tag, "_data"}, {cs_wdata, rf_wr_data}, 64'h0);
  endtask

  // Requests a swap and returns the cycle (after sampling) in which swap_done is seen.
  task automatic run_swap(input logic [1:0] c, input logic [1:0] n, input bit perturb,
                          output int cyc);
    @(negedge clk);
    swap_req = 1'b1;
    cur_sm   = c;
    next_sm  = n;
    cyc      = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (swap_done) begin
        cyc = k;
        break;
      end
      if (perturb) begin
        swap_req = k[0];
        cur_sm   = k[1:0];
        next_sm  = k[2:1];
      end
    end
    swap_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int cyc, b_rf, b_cw, b_cr, b_done;
  bit found;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outs("reset_outs");
    reset    = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    check_idle_outs("idle_outs");

    // Basic swap 1 -> 2
    b_rf = rf_wr_cnt; b_cw = cs_wr_cnt; b_cr = cs_rd_cnt; b_done = done_cnt;
    run_swap(2'd1, 2'd2, 1'b0, cyc);
    check("t1_latency", cyc, 21);
    check("t1_store4", store[4], 32'hA0);
    check("t1_store7", store[7], 32'hA3);
    check("t1_rf0", rf_mem[0], 32'h5008);
    check("t1_rf3", rf_mem[3], 32'h500B);
    check("t1_counts", {cs_wr_cnt - b_cw, cs_rd_cnt - b_cr, rf_wr_cnt - b_rf}, {32'd4, 32'd4, 32'd4});
    check("t1_done_cnt", done_cnt - b_done, 1);

    // Same SM: no traffic
    b_rf = rf_wr_cnt; b_cw = cs_wr_cnt; b_cr = cs_rd_cnt;
    run_swap(2'd3, 2'd3, 1'b0, cyc);
    check("t2_latency", cyc, 1);
    check("t2_traffic", (cs_wr_cnt - b_cw) + (cs_rd_cnt - b_cr) + (rf_wr_cnt - b_rf), 0);

    // Grant stall of 3 cycles on the second save write (addr {0,1})
    stall_used = 0;
    stall_req  = 3;
    run_swap(2'd0, 2'd1, 1'b0, cyc);
    check("t3_latency", cyc, 24);
    check("t3_stall_used", stall_used, 3);
    check("t3_store1", store[1], 32'h5009);
    check("t3_store0", store[0], 32'h5008);
    check("t3_rf2", rf_mem[2], 32'hA2);

    // rvalid 5 cycles late on the last load (addr {3,3})
    slow_en = 1'b1;
    b_rf = rf_wr_cnt;
    run_swap(2'd2, 2'd3, 1'b0, cyc);
    slow_en = 1'b0;
    check("t4_latency", cyc, 26);
    check("t4_rf_writes", rf_wr_cnt - b_rf, 4);
    check("t4_rf3", rf_mem[3], 32'h500F);
    check("t4_rf0", rf_mem[0], 32'h500C);
    check("t4_store11", store[11], 32'hA3);
    check("t4_wr_after_rvalid", seq_err, 0);

    // Reset while in LOAD_REQ
    b_rf = rf_wr_cnt; b_done = done_cnt;
    @(negedge clk);
    swap_req = 1'b1; cur_sm = 2'd0; next_sm = 2'd2;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      swap_req = 1'b0;
      if (cs_req && !cs_we) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_reached_load", found, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outs("t5_abort_outs");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_done", done_cnt - b_done, 0);
    check("t5_no_rf_wr", rf_wr_cnt - b_rf, 0);
    run_swap(2'd1, 2'd2, 1'b0, cyc);
    check("t5_restart_latency", cyc, 21);
    check("t5_rf1", rf_mem[1], 32'hA1);
    check("t5_store5", store[5], 32'h500D);

    // Input changes mid-swap are ignored
    b_done = done_cnt;
    run_swap(2'd2, 2'd0, 1'b1, cyc);
    repeat (5) @(negedge clk);
    check("t6_latency", cyc, 21);
    check("t6_done_cnt", done_cnt - b_done, 1);
    check("t6_store8", store[8], 32'hA0);
    check("t6_store10", store[10], 32'hA2);
    check("t6_rf0", rf_mem[0], 32'h500C);
    check("t6_rf3", rf_mem[3], 32'h500F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
